// File: rtl/relu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : relu_pkg                                                |
// | Brief  : Shared constants and FSM state type for the ReLU layer  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package relu_pkg;

  localparam int          WORD_W   = 32;
  localparam int          SIGN_BIT = 31;
  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/relu_sign_select.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : relu_sign_select                                        |
// | Brief  : Combinational IEEE-754 single ReLU (sign-bit select)    |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module relu_sign_select
  import relu_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              is_neg
);

  // Any set sign bit (including -0.0 and negative NaN) collapses to +0.0.
  assign is_neg = din[SIGN_BIT];
  assign dout   = is_neg ? FP_ZERO : din;

endmodule
`default_nettype wire

// File: rtl/relu_layer_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : relu_layer_sequencer                                    |
// | Brief  : Streams one layer source->ReLU->destination with a      |
// |          2-entry write buffer. Optional RELU_NEG_COUNT_EN adds   |
// |          the neg_count output.                                   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module relu_layer_sequencer
  import relu_pkg::*;
#(
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_rd_addr,
  input  logic [AW-1:0]     base_wr_addr,
  input  logic [LW-1:0]     length,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ready
`ifdef RELU_NEG_COUNT_EN
  ,output logic [LW-1:0]    neg_count
`endif
);

  state_e                   state_q, state_d;
  logic [AW-1:0]            rd_base_q, rd_base_d;
  logic [AW-1:0]            wr_base_q, wr_base_d;
  logic [LW-1:0]            len_q, len_d;
  logic [LW-1:0]            rd_cnt_q, rd_cnt_d;
  logic [LW-1:0]            wr_cnt_q, wr_cnt_d;
  logic                     inflight_q, inflight_d;
  logic [1:0][WORD_W-1:0]   mem_q, mem_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               occ_q, occ_d;

  logic [WORD_W-1:0]        w_relu;
  logic                     w_is_neg;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_room;
  logic                     w_accept;
  logic [AW-1:0]            w_rd_off;
  logic [AW-1:0]            w_wr_off;

  relu_sign_select u_relu (
    .din    (rd_data),
    .dout   (w_relu),
    .is_neg (w_is_neg)
  );

  // Counters and addresses may differ in width; addresses wrap modulo 2^AW.
  if (LW >= AW) begin : g_off_trunc
    assign w_rd_off = rd_cnt_q[AW-1:0];
    assign w_wr_off = wr_cnt_q[AW-1:0];
  end else begin : g_off_ext
    assign w_rd_off = {{(AW-LW){1'b0}}, rd_cnt_q};
    assign w_wr_off = {{(AW-LW){1'b0}}, wr_cnt_q};
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == FIN);
  assign rd_addr = rd_base_q + w_rd_off;
  assign wr_addr = wr_base_q + w_wr_off;
  assign wr_en   = (occ_q != 2'd0);
  assign wr_data = mem_q[rd_ptr_q];

  assign w_pop    = wr_en && wr_ready;
  assign w_push   = inflight_q;
  assign w_accept = (state_q == IDLE) && start;
  // Reserve a slot for every outstanding read so the buffer never overflows.
  assign w_room   = (3'(occ_q) + 3'(inflight_q)) <= (3'd1 + 3'(w_pop));
  assign rd_en    = (state_q == RUN) && (rd_cnt_q < len_q) && w_room;

  always_comb begin
    state_d    = state_q;
    rd_base_d  = rd_base_q;
    wr_base_d  = wr_base_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q + LW'(rd_en);
    wr_cnt_d   = wr_cnt_q + LW'(w_pop);
    inflight_d = rd_en;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q ^ w_push;
    rd_ptr_d   = rd_ptr_q ^ w_pop;
    occ_d      = occ_q + 2'(w_push) - 2'(w_pop);

    if (w_push) begin
      mem_d[wr_ptr_q] = w_relu;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_base_d = base_rd_addr;
          wr_base_d = base_wr_addr;
          len_d     = length;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          state_d   = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (w_pop && ((wr_cnt_q + LW'(1)) == len_q)) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_base_q  <= '0;
      wr_base_q  <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_base_q  <= rd_base_d;
      wr_base_q  <= wr_base_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

`ifdef RELU_NEG_COUNT_EN
  logic [LW-1:0] neg_cnt_q, neg_cnt_d;

  always_comb begin
    neg_cnt_d = neg_cnt_q;
    if (w_accept) begin
      neg_cnt_d = '0;
    end else if (w_push && w_is_neg) begin
      neg_cnt_d = neg_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_cnt_q <= '0;
    end else begin
      neg_cnt_q <= neg_cnt_d;
    end
  end

  assign neg_count = neg_cnt_q;
`else
  logic w_unused_neg;
  assign w_unused_neg = w_is_neg ^ w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_relu_layer_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_relu_layer_sequencer                                 |
// | Brief  : Directed self-checking bench for relu_layer_sequencer   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_relu_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_rd_addr;
  logic [7:0]  base_wr_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
`ifdef RELU_NEG_COUNT_EN
  logic [7:0]  neg_count;
`endif

  logic [31:0] src [256];
  logic [31:0] dst [256];

  int n_cmp = 0;
  int n_err = 0;

  relu_layer_sequencer #(.AW(8), .LW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_rd_addr (base_rd_addr),
    .base_wr_addr (base_wr_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef RELU_NEG_COUNT_EN
    .neg_count    (neg_count),
`endif
    .wr_ready     (wr_ready)
  );

  always #5 clk = ~clk;

  // Source RAM: one-cycle read latency. Destination RAM: written on handshake.
  always @(posedge clk) begin
    rd_data <= rd_en ? src[rd_addr] : 32'h0;
    if (wr_en && wr_ready) dst[wr_addr] <= wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] v1_in  [4] = '{32'h3E4C_CCCD, 32'hBE4C_CCCD, 32'h8000_0000, 32'h7F80_0000};
  logic [31:0] v1_out [4] = '{32'h3E4C_CCCD, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000};
  logic [31:0] v3_in  [6] = '{32'h3F80_0000, 32'hC000_0000, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h7FC0_0000, 32'h8000_0001};
  logic [31:0] v3_out [6] = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0001,
                              32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000};
  logic [31:0] v4_in  [4] = '{32'h1111_1111, 32'hA222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [7:0]  v4_ra  [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  bit          rp     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int nrd;
    int nwr;
    bit seen_done;

    for (int i = 0; i < 256; i++) begin
      src[i] = 32'h0;
      dst[i] = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < 4; i++) src[8'h10 + i] = v1_in[i];
    for (int i = 0; i < 6; i++) src[8'h40 + i] = v3_in[i];
    for (int i = 0; i < 4; i++) src[v4_ra[i]] = v4_in[i];

    rst = 1'b1; start = 1'b0; base_rd_addr = '0; base_wr_addr = '0;
    length = '0; wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);

    // Test 1: basic stream, full throughput, exact cycle timing.
    @(negedge clk);
    start = 1'b1; base_rd_addr = 8'h10; base_wr_addr = 8'h20; length = 8'd4; wr_ready = 1'b1;
    #1;
    chk("t1_busy_c0", 32'(busy), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk($sformatf("t1_rd_en_c%0d", k), 32'(rd_en), 32'(k >= 1 && k <= 4));
      chk($sformatf("t1_wr_en_c%0d", k), 32'(wr_en), 32'(k >= 3 && k <= 6));
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 7));
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 6));
      if (k >= 1 && k <= 4) chk($sformatf("t1_rd_addr_c%0d", k), 32'(rd_addr), 32'h10 + k - 1);
      if (k >= 3 && k <= 6) begin
        chk($sformatf("t1_wr_addr_c%0d", k), 32'(wr_addr), 32'h20 + k - 3);
        chk($sformatf("t1_wr_data_c%0d", k), wr_data, v1_out[k-3]);
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t1_dst%0d", i), dst[8'h20 + i], v1_out[i]);
`ifdef RELU_NEG_COUNT_EN
    chk("t1_neg_count", 32'(neg_count), 2);
`endif

    // Test 2: zero length completes without memory traffic.
    @(negedge clk);
    start = 1'b1; length = 8'd0;
    #1;
    chk("t2_rd_en_c0", 32'(rd_en), 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("t2_done_c1", 32'(done), 1);
    chk("t2_busy_c1", 32'(busy), 0);
    chk("t2_rd_en_c1", 32'(rd_en), 0);
    chk("t2_wr_en_c1", 32'(wr_en), 0);
    @(negedge clk);
    #1;
    chk("t2_done_c2", 32'(done), 0);
    chk("t2_wr_en_c2", 32'(wr_en), 0);

    // Test 3: back-pressure pattern 1,0,0,1.
    @(negedge clk);
    start = 1'b1; base_rd_addr = 8'h40; base_wr_addr = 8'h80; length = 8'd6; wr_ready = 1'b1;
    nrd = 0; nwr = 0; seen_done = 1'b0;
    for (int c = 1; c <= 80 && !seen_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      wr_ready = rp[c % 4];
      #1;
      if (done) seen_done = 1'b1;
      if (rd_en) begin
        chk($sformatf("t3_rd_addr_%0d", nrd), 32'(rd_addr), 32'h40 + nrd);
        nrd++;
      end
      if (wr_en) begin
        chk($sformatf("t3_wr_addr_c%0d", c), 32'(wr_addr), 32'h80 + nwr);
        chk($sformatf("t3_wr_data_c%0d", c), wr_data, (nwr < 6) ? v3_out[nwr] : 32'hDEAD_BEEF);
        if (wr_ready) nwr++;
      end
      if ((nrd - nwr) > 2) chk($sformatf("t3_outstanding_c%0d", c), 32'(nrd - nwr), 2);
    end
    chk("t3_done_seen", 32'(seen_done), 1);
    chk("t3_reads", 32'(nrd), 6);
    chk("t3_writes", 32'(nwr), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_dst%0d", i), dst[8'h80 + i], v3_out[i]);
`ifdef RELU_NEG_COUNT_EN
    chk("t3_neg_count", 32'(neg_count), 3);
`endif

    // Test 4: source address wrap.
    @(negedge clk);
    start = 1'b1; base_rd_addr = 8'hFE; base_wr_addr = 8'h60; length = 8'd4; wr_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (k <= 4) chk($sformatf("t4_rd_addr_c%0d", k), 32'(rd_addr), 32'(v4_ra[k-1]));
      if (k == 7) chk("t4_done_c7", 32'(done), 1);
    end
    chk("t4_dst2", dst[8'h62], 32'h3333_3333);
    chk("t4_dst1", dst[8'h61], 32'h0000_0000);

    // Test 5: reset in the cycle after the second write, then a clean run.
    @(negedge clk);
    start = 1'b1; base_rd_addr = 8'h10; base_wr_addr = 8'h30; length = 8'd4; wr_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_rd_en", 32'(rd_en), 0);
    chk("t5_rd_addr", 32'(rd_addr), 0);
    chk("t5_wr_en", 32'(wr_en), 0);
    chk("t5_wr_addr", 32'(wr_addr), 0);
    chk("t5_wr_data", wr_data, 0);
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done || wr_en || rd_en) seen_done = 1'b1;
    end
    chk("t5_quiet_after_rst", 32'(seen_done), 0);

    @(negedge clk);
    start = 1'b1; base_rd_addr = 8'h10; base_wr_addr = 8'h50; length = 8'd4; wr_ready = 1'b1;
    seen_done = 1'b0;
    for (int c = 1; c <= 20 && !seen_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("t5_rerun_done", 32'(seen_done), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_dst%0d", i), dst[8'h50 + i], v1_out[i]);
`ifdef RELU_NEG_COUNT_EN
    chk("t5_neg_count", 32'(neg_count), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
